dec_4x16_seq: RTL and testbench
===============================

// Module: dec_4x16_seq
// PURPOSE
//  Sequenced 4-to-16 decoder: the receive-side counterpart of the team's 16x4 one-hot encoder.
//  Accepts a binary code over a valid/ready handshake and drives the one-hot line for HOLD cycles.
//  Also provides an auto-scan mode that walks all 16 lines, for LED/keypad row strobing.
//  Sits between a code source (encoder, CPU register) and one-hot select lines.
// PARAMETERS
//  W     4   code width; N = 2**W output lines (localparam, not overridable)
//  HOLD  4   cycles each one-hot line stays asserted; legal range HOLD >= 1
// PORTS
//  clk       in   1   single clock, rising edge
//  rst_n     in   1   asynchronous reset, active-low
//  en        in   1   block enable; low = abort and force idle
//  scan      in   1   request auto-scan mode
//  in_valid  in   1   in_code is valid
//  in_code   in   W   binary code to decode
//  in_ready  out  1   block accepts a code this cycle
//  out       out  N   one-hot decoded lines (all-zero when inactive)
//  busy      out  1   high in HOLD or SCAN
//  done      out  1   one-cycle pulse when an operation completes normally
// BEHAVIOUR
//  - Reset (rst_n=0, immediate): state=IDLE, out=0, busy=0, done=0, hold count=0, scan idx=0.
//  - in_ready = (state==IDLE) & en & ~scan (combinational). Scan has priority over the handshake.
//  - out, busy and done are registered. out is always one-hot or zero, never multi-hot.
//  - FSM states: IDLE, HOLD, SCAN.
//  - IDLE -> HOLD on in_valid & in_ready at an edge.
//    - Next cycle: out = 1<<in_code, busy=1, cnt=HOLD-1. Latency is 1 cycle.
//  - HOLD: cnt decrements each cycle. At the edge where cnt==0:
//    - out=0, busy=0, done=1 for one cycle, state -> IDLE.
//    - out is therefore high for exactly HOLD cycles.
//  - IDLE -> SCAN when en & scan.
//    - idx=0, out=16'h0001, cnt=HOLD-1, busy=1.
//  - SCAN: each idx is held HOLD cycles. At slot end, scan is sampled:
//    - scan=1: idx = idx+1 (15 wraps to 0), out = 1<<idx, cnt reloads.
//    - scan=0: out=0, busy=0, done=1 pulse, state -> IDLE.
//  - en=0 in any state: next edge gives state=IDLE, out=0, busy=0, no done pulse. Counters clear.
//  - in_valid while busy: ignored, since in_ready=0. The sender must hold in_valid and in_code until accepted.
//  - in_code is captured only at acceptance. Later changes to in_code do not affect out.
//  - done and a new acceptance cannot share a cycle.
//    - in_ready rises in the cycle done is high, so the earliest back-to-back accept leaves >= 1 cycle of out=0 between codes.
//  - scan rising during HOLD: the current HOLD completes (done pulses), then SCAN is entered from IDLE.
//  - Counter width = max(1, $clog2(HOLD)). For HOLD=1, cnt is 0 and every slot is 1 cycle.
// STRUCTURE
//  - Package dec_pkg: state enum (IDLE, HOLD, SCAN), W default, and the onehot(code) function.
//  - Sub-module hold_timer: down-counter with load, decrement and zero flag, parameterised by HOLD.
//  - Top level: FSM, code/idx register, one-hot output register.
// TESTING
//  1. Reset: rst_n=0, en=1, in_valid=1
//     -> out=16'h0000, busy=0, done=0. After release, in_ready=1.
//  2. HOLD=4, in_code=9 valid for 1 cycle
//     -> out=16'h0200 for cycles +1..+4. Cycle +5: out=0, done=1. Then in_ready=1.
//  3. While busy, present in_code=3 with in_valid held
//     -> in_ready=0 until IDLE. The code is then accepted: out=16'h0008, and the original code is unaffected.
//  4. HOLD=1, scan=1 for 18 cycles, then scan=0
//     -> out 0001, 0002, ..., 8000, 0001, 0002. Then out=0, done=1.
//  5. en=0 mid-HOLD -> out=0 next cycle, no done.
//     rst_n=0 mid-SCAN -> out=0 immediately, without a clock edge.
//  6. Boundary codes 0 and 15 back-to-back -> out=16'h0001, then 0, then 16'h8000. Never two bits set.

Source files
------------

// File: rtl/dec_pkg.sv
// Shared types and helpers for the sequenced 4-to-16 decoder.
package dec_pkg;

  localparam int unsigned W_DEF = 4;
  localparam int unsigned N_DEF = 1 << W_DEF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HOLD = 2'd1,
    ST_SCAN = 2'd2
  } state_t;

  // Binary code to one-hot line; exactly one bit set for every code.
  function automatic logic [N_DEF-1:0] onehot(input logic [W_DEF-1:0] code);
    logic [N_DEF-1:0] v;
    v       = '0;
    v[code] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/hold_timer.sv
// Down-counter timing how long each one-hot line stays asserted.
module hold_timer #(
  parameter int unsigned HOLD = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clear,
  input  logic i_load,
  input  logic i_dec,
  output logic o_zero
);

  localparam int unsigned CW = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam logic [CW-1:0] LOAD_VAL = CW'(HOLD - 1);

  logic [CW-1:0] r_cnt;

  // Clear beats load beats decrement; the count parks at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= LOAD_VAL;
    end else if (i_dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - CW'(1);
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/dec_4x16_seq.sv
// Sequenced 4-to-16 decoder with valid/ready code intake and auto-scan mode.
module dec_4x16_seq
  import dec_pkg::*;
#(
  parameter int unsigned HOLD = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en,
  input  logic                     scan,
  input  logic                     in_valid,
  input  logic [W_DEF-1:0]         in_code,
  output logic                     in_ready,
  output logic [(1 << W_DEF)-1:0]  out,
  output logic                     busy,
  output logic                     done
);

  localparam int unsigned W = W_DEF;
  localparam int unsigned N = 1 << W;

  state_t         r_state, w_state_nxt;
  logic [N-1:0]   r_out,   w_out_nxt;
  logic           r_busy,  w_busy_nxt;
  logic           r_done,  w_done_nxt;
  logic [W-1:0]   r_idx,   w_idx_nxt;
  logic [W-1:0]   w_idx_inc;
  logic           w_clr, w_load, w_dec, w_zero;

  assign w_idx_inc = r_idx + W'(1);
  assign in_ready  = (r_state == ST_IDLE) && en && !scan;

  hold_timer #(
    .HOLD (HOLD)
  ) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_clear (w_clr),
    .i_load  (w_load),
    .i_dec   (w_dec),
    .o_zero  (w_zero)
  );

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_out   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_out   <= w_out_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
      r_idx   <= w_idx_nxt;
    end
  end

  // Next state, next outputs and timer control.
  always_comb begin
    w_state_nxt = r_state;
    w_out_nxt   = r_out;
    w_busy_nxt  = r_busy;
    w_done_nxt  = 1'b0;
    w_idx_nxt   = r_idx;
    w_clr       = 1'b0;
    w_load      = 1'b0;
    w_dec       = 1'b0;

    if (!en) begin
      w_state_nxt = ST_IDLE;
      w_out_nxt   = '0;
      w_busy_nxt  = 1'b0;
      w_idx_nxt   = '0;
      w_clr       = 1'b1;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          // Scan wins over the handshake, matching in_ready.
          if (scan) begin
            w_state_nxt = ST_SCAN;
            w_idx_nxt   = '0;
            w_out_nxt   = onehot('0);
            w_busy_nxt  = 1'b1;
            w_load      = 1'b1;
          end else if (in_valid) begin
            w_state_nxt = ST_HOLD;
            w_out_nxt   = onehot(in_code);
            w_busy_nxt  = 1'b1;
            w_load      = 1'b1;
          end
        end
        ST_HOLD: begin
          if (w_zero) begin
            w_state_nxt = ST_IDLE;
            w_out_nxt   = '0;
            w_busy_nxt  = 1'b0;
            w_done_nxt  = 1'b1;
          end else begin
            w_dec = 1'b1;
          end
        end
        ST_SCAN: begin
          if (!w_zero) begin
            w_dec = 1'b1;
          end else if (scan) begin
            w_idx_nxt = w_idx_inc;
            w_out_nxt = onehot(w_idx_inc);
            w_load    = 1'b1;
          end else begin
            w_state_nxt = ST_IDLE;
            w_out_nxt   = '0;
            w_busy_nxt  = 1'b0;
            w_done_nxt  = 1'b1;
          end
        end
        default: begin
          w_state_nxt = ST_IDLE;
          w_out_nxt   = '0;
          w_busy_nxt  = 1'b0;
          w_clr       = 1'b1;
        end
      endcase
    end
  end

  assign out  = r_out;
  assign busy = r_busy;
  assign done = r_done;

endmodule

// File: tb/tb_dec_4x16_seq.sv
// Bench for dec_4x16_seq: HOLD=4 and HOLD=1 instances share stimulus and are
// each compared against a queue-of-future-lines reference.
module tb_dec_4x16_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic        scan;
  logic        in_valid;
  logic [3:0]  in_code;

  logic        r4, b4, d4;
  logic [15:0] o4;
  logic        r1, b1, d1;
  logic [15:0] o1;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  dec_4x16_seq #(.HOLD(4)) u_h4 (
    .clk(clk), .rst_n(rst_n), .en(en), .scan(scan), .in_valid(in_valid),
    .in_code(in_code), .in_ready(r4), .out(o4), .busy(b4), .done(d4)
  );

  dec_4x16_seq #(.HOLD(1)) u_h1 (
    .clk(clk), .rst_n(rst_n), .en(en), .scan(scan), .in_valid(in_valid),
    .in_code(in_code), .in_ready(r1), .out(o1), .busy(b1), .done(d1)
  );

  // Reference: each instance owns a queue holding the line number to be shown
  // in every upcoming cycle; empty queue means idle.
  int unsigned hv [2] = '{4, 1};
  int          q    [2][$];
  bit          m_done [2];
  bit          m_scanning [2];
  int          m_sidx [2];

  function automatic void model_reset();
    for (int m = 0; m < 2; m++) begin
      q[m].delete();
      m_done[m]     = 1'b0;
      m_scanning[m] = 1'b0;
      m_sidx[m]     = 0;
    end
  endfunction

  function automatic void push_slot(int m, int line);
    for (int unsigned k = 0; k < hv[m]; k++) q[m].push_back(line);
  endfunction

  function automatic void model_edge();
    for (int m = 0; m < 2; m++) begin
      m_done[m] = 1'b0;
      if (!rst_n || !en) begin
        q[m].delete();
        m_scanning[m] = 1'b0;
        m_sidx[m]     = 0;
      end else if (q[m].size() == 0) begin
        if (scan) begin
          m_scanning[m] = 1'b1;
          m_sidx[m]     = 0;
          push_slot(m, 0);
        end else if (in_valid) begin
          m_scanning[m] = 1'b0;
          push_slot(m, int'(in_code));
        end
      end else begin
        void'(q[m].pop_front());
        if (q[m].size() == 0) begin
          if (m_scanning[m] && scan) begin
            m_sidx[m] = (m_sidx[m] + 1) % 16;
            push_slot(m, m_sidx[m]);
          end else begin
            m_done[m]     = 1'b1;
            m_scanning[m] = 1'b0;
          end
        end
      end
    end
  endfunction

  function automatic logic [15:0] m_out(int m);
    logic [15:0] one;
    one = 16'h0001;
    if (q[m].size() == 0) return 16'h0000;
    return one << q[m][0];
  endfunction

  function automatic logic m_busy(int m);
    return q[m].size() != 0;
  endfunction

  function automatic logic m_ready(int m);
    return (q[m].size() == 0) && en && !scan;
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_outs();
    chk("h4_out",  o4, m_out(0));
    chk("h4_busy", {15'b0, b4}, {15'b0, m_busy(0)});
    chk("h4_done", {15'b0, d4}, {15'b0, m_done[0]});
    chk("h4_onehot0", {15'b0, $onehot0(o4)}, 16'h0001);
    chk("h1_out",  o1, m_out(1));
    chk("h1_busy", {15'b0, b1}, {15'b0, m_busy(1)});
    chk("h1_done", {15'b0, d1}, {15'b0, m_done[1]});
    chk("h1_onehot0", {15'b0, $onehot0(o1)}, 16'h0001);
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
    check_outs();
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic drive(input logic e, input logic s, input logic v, input logic [3:0] c);
    en       = e;
    scan     = s;
    in_valid = v;
    in_code  = c;
    #1;
    chk("h4_ready", {15'b0, r4}, {15'b0, m_ready(0)});
    chk("h1_ready", {15'b0, r1}, {15'b0, m_ready(1)});
  endtask

  initial begin
    // Reset with a valid code pending: nothing may start.
    rst_n = 1'b0; en = 1'b1; scan = 1'b0; in_valid = 1'b1; in_code = 4'd5;
    model_reset();
    #1;
    check_outs();
    cycles(2);
    #1;
    rst_n = 1'b1;
    drive(1'b1, 1'b0, 1'b0, 4'd0);
    cycle();

    // Single code 9 valid for one cycle.
    drive(1'b1, 1'b0, 1'b1, 4'd9);
    cycle();
    chk("h4_code9", o4, 16'h0200);
    drive(1'b1, 1'b0, 1'b0, 4'd9);
    cycles(6);

    // Code 3 held while busy with code 9; accepted only once idle.
    drive(1'b1, 1'b0, 1'b1, 4'd9);
    cycle();
    drive(1'b1, 1'b0, 1'b1, 4'd3);
    for (int i = 0; i < 12; i++) begin
      cycle();
      drive(1'b1, 1'b0, 1'b1, 4'd3);
    end
    drive(1'b1, 1'b0, 1'b0, 4'd3);
    cycles(6);

    // Auto-scan for 18 cycles, then release.
    drive(1'b1, 1'b1, 1'b0, 4'd0);
    cycles(18);
    drive(1'b1, 1'b0, 1'b0, 4'd0);
    cycles(6);

    // en low mid-HOLD: abort without done.
    drive(1'b1, 1'b0, 1'b1, 4'd6);
    cycle();
    drive(1'b1, 1'b0, 1'b0, 4'd6);
    cycle();
    drive(1'b0, 1'b0, 1'b0, 4'd6);
    cycle();
    chk("h4_abort_out", o4, 16'h0000);
    drive(1'b1, 1'b0, 1'b0, 4'd0);
    cycles(2);

    // Asynchronous reset mid-SCAN.
    drive(1'b1, 1'b1, 1'b0, 4'd0);
    cycles(7);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("h4_async_rst_out", o4, 16'h0000);
    chk("h1_async_rst_out", o1, 16'h0000);
    check_outs();
    drive(1'b1, 1'b0, 1'b0, 4'd0);
    cycle();
    #1;
    rst_n = 1'b1;
    cycle();

    // Boundary codes 0 then 15 back-to-back.
    drive(1'b1, 1'b0, 1'b1, 4'd0);
    cycle();
    drive(1'b1, 1'b0, 1'b1, 4'd15);
    for (int i = 0; i < 12; i++) begin
      cycle();
      drive(1'b1, 1'b0, 1'b1, 4'd15);
    end
    drive(1'b1, 1'b0, 1'b0, 4'd0);
    cycles(6);

    // Randomised traffic.
    for (int i = 0; i < 600; i++) begin
      logic e, s, v;
      logic [3:0] c;
      e = ($urandom_range(0, 24) != 0);
      s = (i % 100 < 20) ? ($urandom_range(0, 9) != 0) : ($urandom_range(0, 29) == 0);
      v = ($urandom_range(0, 1) == 1);
      c = 4'($urandom_range(0, 15));
      drive(e, s, v, c);
      cycle();
    end

    drive(1'b1, 1'b0, 1'b0, 4'd0);
    cycles(20);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
